dmem_responder: RTL and testbench

- Data-memory responder for the RISC-V memory stage: the target end of the memory-stage-to-data-RAM interface.
- Accepts one load/store request at a time via a ready/req handshake, waits a configurable number of cycles, and performs a byte-lane-correct write.
- Returns load data already sign/zero-extended per funct3, with an error flag for misaligned, out-of-range or unsupported accesses.
- Replaces the combinational RAM stub so the memory stage can stall on a real memory latency.

---
 rtl/dmem_responder_if.sv | 35 +++
 rtl/dmem_responder.sv | 227 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Memory-stage <-> data-RAM request/response bundle.
//   mem2ram_req_i     request strobe, seen only while ram2mem_ready_o=1
//   mem2ram_we_i      1=store, 0=load
//   mem2ram_addr_i    byte address
//   mem2ram_data_i    right-aligned store data
//   mem2ram_funct3_i  RISC-V load/store funct3
//   ram2mem_ready_o   responder idle, can accept a request
//   ram2mem_valid_o   one-cycle response strobe
//   ram2mem_data_o    extended load data (0 for stores/errors)
//   ram2mem_err_o     access rejected, qualified by valid
// Modports: master = memory stage, slave = responder.
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        mem2ram_req_i;
  logic        mem2ram_we_i;
  logic [31:0] mem2ram_addr_i;
  logic [31:0] mem2ram_data_i;
  logic [2:0]  mem2ram_funct3_i;
  logic        ram2mem_ready_o;
  logic        ram2mem_valid_o;
  logic [31:0] ram2mem_data_o;
  logic        ram2mem_err_o;

  modport master (
    output mem2ram_req_i, mem2ram_we_i, mem2ram_addr_i, mem2ram_data_i, mem2ram_funct3_i,
    input  ram2mem_ready_o, ram2mem_valid_o, ram2mem_data_o, ram2mem_err_o
  );

  modport slave (
    input  mem2ram_req_i, mem2ram_we_i, mem2ram_addr_i, mem2ram_data_i, mem2ram_funct3_i,
    output ram2mem_ready_o, ram2mem_valid_o, ram2mem_data_o, ram2mem_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the RISC-V memory stage. Accepts one load/store at
// a time, waits WAIT_STATES cycles, performs a byte-lane write or an
// extended read, and returns a one-cycle response with an error flag.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    dmem_responder_if.slave (request in, response out)
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (word index = addr[31:2])
//   WAIT_STATES  extra cycles between accept and response (0 allowed)
//
// Build option:
//   DMEM_MISALIGN_TRAP_EN  defined   -> misaligned half/word accesses error
//                          undefined -> low address bits are masked to
//                                       natural alignment and the access
//                                       proceeds
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [2:0]        acc_f3;
  logic [31:0]       eff_addr;
  logic              f3_ok;
  logic              misaligned;
  logic              align_err;
  logic              range_err;
  logic              acc_err;
  logic [IDX_W-1:0]  word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_value;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic              go_resp;

  // Access fields seen by the decode. While idle the live bus fields are
  // used, because with zero wait states the access completes on the very
  // edge that accepts it; otherwise the captured copy is used.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_f3    = funct3_q;
    if (state_q == ST_IDLE) begin
      acc_we    = bus.mem2ram_we_i;
      acc_addr  = bus.mem2ram_addr_i;
      acc_wdata = bus.mem2ram_data_i;
      acc_f3    = bus.mem2ram_funct3_i;
    end
  end

  // Access decode: legality, effective address, load extension and the
  // store byte-lane enables/replicated data.
  always_comb begin
    if (acc_we) f3_ok = acc_f3 inside {3'b000, 3'b001, 3'b010};
    else        f3_ok = acc_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    misaligned = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                 ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));

`ifdef DMEM_MISALIGN_TRAP_EN
    align_err = misaligned;
    eff_addr  = acc_addr;
`else
    align_err = 1'b0;
    eff_addr  = acc_addr;
    if (acc_f3[1:0] == 2'b01) eff_addr[0]   = 1'b0;
    if (acc_f3[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif

    range_err = ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
    acc_err   = !f3_ok || range_err || align_err;

    word_idx = eff_addr[IDX_W+1:2];
    rd_word  = mem_q[word_idx];

    case (eff_addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

    case (acc_f3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_value = rd_word;
      3'b100:  ld_value = {24'h0, ld_byte};
      3'b101:  ld_value = {16'h0, ld_half};
      default: ld_value = 32'h0;
    endcase

    case (acc_f3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << eff_addr[1:0];
        wr_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = acc_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = 32'h0;
      end
    endcase
  end

  // Next-state logic: IDLE accepts and captures, WAIT counts down the
  // configured latency, RESP lasts one cycle. Results are registered on
  // the edge that enters RESP, which is also when a store commits.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem2ram_req_i) begin
          we_d     = bus.mem2ram_we_i;
          addr_d   = bus.mem2ram_addr_i;
          wdata_d  = bus.mem2ram_data_i;
          funct3_d = bus.mem2ram_funct3_i;
          state_d  = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    go_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    wr_en   = go_resp && acc_we && !acc_err;
    if (go_resp) begin
      err_d   = acc_err;
      rdata_d = (acc_we || acc_err) ? 32'h0 : ld_value;
    end
  end

  // Control and captured-request registers; reset discards any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Storage array, never cleared. The rst_n term stops a zero-wait store
  // presented during reset from being committed.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign bus.ram2mem_ready_o = (state_q == ST_IDLE);
  assign bus.ram2mem_valid_o = (state_q == ST_RESP);
  assign bus.ram2mem_data_o  = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign bus.ram2mem_err_o   = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder (DEPTH_WORDS=1024, WAIT_STATES=1).
// A table of load/store vectors with hand-computed results is run first,
// followed by hand-written sequences for async reset, req held through
// RESP, and misaligned accesses (expectations follow
// DMEM_MISALIGN_TRAP_EN).
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  vec_t vecs[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts the test and reports a miss.
  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3,
                                 input logic [31:0] exp_data, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  // Drives one request, scrambles the inputs after acceptance, waits
  // (bounded) for valid, and checks ready/valid around the response.
  task automatic applyStimulus(input vec_t v, input int idx,
                               output logic [31:0] got_data, output logic got_err,
                               output int lat);
    @(negedge clk);
    checkOutput("ready_before_req", idx, 32'(bus.ram2mem_ready_o), 32'd1);
    bus.mem2ram_we_i     = v.we;
    bus.mem2ram_addr_i   = v.addr;
    bus.mem2ram_data_i   = v.wdata;
    bus.mem2ram_funct3_i = v.f3;
    bus.mem2ram_req_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem2ram_req_i    = 1'b0;
    bus.mem2ram_we_i     = ~v.we;
    bus.mem2ram_addr_i   = 32'hFFFF_FFFF;
    bus.mem2ram_data_i   = $urandom;
    bus.mem2ram_funct3_i = 3'b111;
    lat      = -1;
    got_data = 32'h0;
    got_err  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checkOutput("ready_busy", idx, 32'(bus.ram2mem_ready_o), 32'd0);
      if (bus.ram2mem_valid_o) begin
        lat      = c;
        got_data = bus.ram2mem_data_o;
        got_err  = bus.ram2mem_err_o;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      checkOutput("valid_one_cycle", idx, 32'(bus.ram2mem_valid_o), 32'd0);
      checkOutput("ready_after_resp", idx, 32'(bus.ram2mem_ready_o), 32'd1);
    end
  endtask

  task automatic doAccess(input vec_t v, input int idx);
    logic [31:0] d;
    logic        e;
    int          lat;
    applyStimulus(v, idx, d, e, lat);
    checkOutput("latency", idx, 32'(lat), 32'(WS + 1));
    checkOutput("data", idx, d, v.exp_data);
    checkOutput("err", idx, 32'(e), 32'(v.exp_err));
  endtask

  initial begin
    logic [31:0] word10;
    tests = 0;
    fails = 0;

    bus.mem2ram_req_i    = 1'b0;
    bus.mem2ram_we_i     = 1'b0;
    bus.mem2ram_addr_i   = 32'h0;
    bus.mem2ram_data_i   = 32'h0;
    bus.mem2ram_funct3_i = 3'b000;
    rst_n = 1'b0;

    // Vector table: {we, addr, wdata, funct3, expected data, expected err}
    vecs.push_back(mkVec(1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0)); // SW
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0)); // LW
    vecs.push_back(mkVec(1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0)); // LB
    vecs.push_back(mkVec(1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0)); // LBU
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b001, 32'hFFFFBEEF, 1'b0)); // LH
    vecs.push_back(mkVec(1'b0, 32'h12,   32'h0,        3'b101, 32'h0000DEAD, 1'b0)); // LHU
    vecs.push_back(mkVec(1'b1, 32'h11,   32'h00000055, 3'b000, 32'h0,        1'b0)); // SB
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0)); // LW
    vecs.push_back(mkVec(1'b1, 32'h12,   32'h00001234, 3'b001, 32'h0,        1'b0)); // SH
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0)); // LW
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b000, 32'hFFFFFFEF, 1'b0)); // LB
    vecs.push_back(mkVec(1'b0, 32'h11,   32'h0,        3'b100, 32'h00000055, 1'b0)); // LBU
    vecs.push_back(mkVec(1'b0, 32'h12,   32'h0,        3'b001, 32'h00001234, 1'b0)); // LH +
    vecs.push_back(mkVec(1'b1, 32'hFFC,  32'h80000001, 3'b010, 32'h0,        1'b0)); // SW last
    vecs.push_back(mkVec(1'b0, 32'hFFE,  32'h0,        3'b001, 32'hFFFF8000, 1'b0)); // LH last
    vecs.push_back(mkVec(1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1)); // range
    vecs.push_back(mkVec(1'b1, 32'h1000, 32'h11111111, 3'b010, 32'h0,        1'b1)); // range st
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b011, 32'h0,        1'b1)); // ld f3 011
    vecs.push_back(mkVec(1'b1, 32'h10,   32'hFFFFFFFF, 3'b100, 32'h0,        1'b1)); // st f3 100
    vecs.push_back(mkVec(1'b0, 32'h10,   32'h0,        3'b010, 32'h123455EF, 1'b0)); // no write
    vecs.push_back(mkVec(1'b0, 32'hFFC,  32'h0,        3'b010, 32'h80000001, 1'b0)); // LW last

    // Reset state while rst_n is held low.
    #3;
    checkOutput("reset_ready", 0, 32'(bus.ram2mem_ready_o), 32'd1);
    checkOutput("reset_valid", 0, 32'(bus.ram2mem_valid_o), 32'd0);
    checkOutput("reset_data",  0, bus.ram2mem_data_o,       32'h0);
    checkOutput("reset_err",   0, 32'(bus.ram2mem_err_o),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) doAccess(vecs[i], i);

    // Async reset during WAIT of a store: the store must be dropped.
    doAccess(mkVec(1'b1, 32'h20, 32'h11223344, 3'b010, 32'h0, 1'b0), 100);
    @(negedge clk);
    bus.mem2ram_we_i     = 1'b1;
    bus.mem2ram_addr_i   = 32'h20;
    bus.mem2ram_data_i   = 32'hCAFEF00D;
    bus.mem2ram_funct3_i = 3'b010;
    bus.mem2ram_req_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.mem2ram_req_i = 1'b0;
    #1;
    checkOutput("wait_ready", 101, 32'(bus.ram2mem_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("async_ready", 101, 32'(bus.ram2mem_ready_o), 32'd1);
    checkOutput("async_valid", 101, 32'(bus.ram2mem_valid_o), 32'd0);
    checkOutput("async_data",  101, bus.ram2mem_data_o,       32'h0);
    checkOutput("async_err",   101, 32'(bus.ram2mem_err_o),   32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doAccess(mkVec(1'b0, 32'h20, 32'h0, 3'b010, 32'h11223344, 1'b0), 102);

    // req held high through RESP: no accept until back in IDLE.
    @(negedge clk);
    bus.mem2ram_we_i     = 1'b0;
    bus.mem2ram_addr_i   = 32'h10;
    bus.mem2ram_funct3_i = 3'b010;
    bus.mem2ram_req_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("held_wait_ready", 103, 32'(bus.ram2mem_ready_o), 32'd0);
    checkOutput("held_wait_valid", 103, 32'(bus.ram2mem_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("held_resp_valid", 103, 32'(bus.ram2mem_valid_o), 32'd1);
    checkOutput("held_resp_data",  103, bus.ram2mem_data_o,       32'h123455EF);
    @(negedge clk);
    checkOutput("held_idle_ready", 103, 32'(bus.ram2mem_ready_o), 32'd1);
    checkOutput("held_idle_valid", 103, 32'(bus.ram2mem_valid_o), 32'd0);
    @(negedge clk);
    checkOutput("held_reaccept",   103, 32'(bus.ram2mem_ready_o), 32'd0);
    bus.mem2ram_req_i = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.ram2mem_valid_o) begin
          seen = 1;
          checkOutput("held_second_data", 103, bus.ram2mem_data_o, 32'h123455EF);
          break;
        end
      end
      checkOutput("held_second_seen", 103, 32'(seen), 32'd1);
    end
    @(negedge clk);

    // Misaligned accesses.
`ifdef DMEM_MISALIGN_TRAP_EN
    word10 = 32'h123455EF;
    doAccess(mkVec(1'b0, 32'h11, 32'h0,    3'b010, 32'h0, 1'b1), 200); // LW misaligned
    doAccess(mkVec(1'b1, 32'h13, 32'hAAAA, 3'b001, 32'h0, 1'b1), 201); // SH misaligned
    doAccess(mkVec(1'b0, 32'h13, 32'h0,    3'b101, 32'h0, 1'b1), 202); // LHU misaligned
`else
    word10 = 32'hAAAA55EF;
    doAccess(mkVec(1'b0, 32'h11, 32'h0,    3'b010, 32'h123455EF, 1'b0), 200); // LW masked
    doAccess(mkVec(1'b1, 32'h13, 32'hAAAA, 3'b001, 32'h0,        1'b0), 201); // SH -> 0x12
    doAccess(mkVec(1'b0, 32'h13, 32'h0,    3'b101, 32'h0000AAAA, 1'b0), 202); // LHU -> 0x12
`endif
    doAccess(mkVec(1'b0, 32'h10, 32'h0, 3'b010, word10, 1'b0), 203);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
